a2_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 8-bit pipelined datapath.
- Holds the program counter and a loadable 64x8 instruction memory.
- Each fetched instruction is latched into IF/ID. The 6-bit immediate field if_id_imm6 drives the downstream zero extender's 6-bit input directly.
- Supports stall from hazard logic, and redirect/flush from branch resolution.

---
 rtl/a2_fetch_stage.sv | 98 +++++++++
 tb/tb_a2_fetch_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/a2_fetch_stage.sv
// a2_fetch_stage: instruction-fetch stage and IF/ID pipeline register for the
// 8-bit pipelined datapath.
//
// Holds the program counter and a loadable instruction memory with
// 2**PC_WIDTH entries. The memory is written synchronously and read
// combinationally at pc. On each rising edge the stage does exactly one of the
// following, in this priority order:
//   reset > load_en > redirect > stall > normal fetch
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset (memory is not cleared)
//   load_en      in   memory write enable; halts fetch and parks pc at 0
//   load_addr    in   memory write address
//   load_data    in   memory write data
//   stall        in   hold pc and IF/ID
//   redirect     in   taken branch/jump; load pc, flush IF/ID
//   redirect_pc  in   redirect target
//   pc           out  current fetch address
//   if_id_instr  out  latched instruction (NOP when invalid)
//   if_id_imm6   out  if_id_instr[5:0], drives the zero extender
//   if_id_pc     out  address the latched instruction came from
//   if_id_valid  out  IF/ID holds a real instruction
module a2_fetch_stage #(
  parameter int unsigned            PC_WIDTH    = 6,
  parameter int unsigned            INSTR_WIDTH = 8,
  parameter logic [INSTR_WIDTH-1:0] NOP         = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [PC_WIDTH-1:0]    load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [5:0]             if_id_imm6,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic                   if_id_valid
);

  localparam int unsigned Depth = 2 ** PC_WIDTH;

  logic [INSTR_WIDTH-1:0] r_mem [Depth];
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_if_id_instr;
  logic [PC_WIDTH-1:0]    r_if_id_pc;
  logic                   r_if_id_valid;

  logic [INSTR_WIDTH-1:0] w_fetch_instr;
  logic [PC_WIDTH-1:0]    w_pc_inc;

  assign w_fetch_instr = r_mem[r_pc];
  // Natural overflow of the PC_WIDTH-bit add gives the 63 -> 0 wrap.
  assign w_pc_inc      = r_pc + PC_WIDTH'(1);

  // Memory contents survive reset; only the write port is gated by it.
  always_ff @(posedge clk) begin
    if (!reset && load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= '0;
      r_if_id_instr <= NOP;
      r_if_id_pc    <= '0;
      r_if_id_valid <= 1'b0;
    end else if (load_en) begin
      // Park at 0 so mem[0] is the first fetch once loading finishes.
      r_pc          <= '0;
      r_if_id_instr <= NOP;
      r_if_id_pc    <= '0;
      r_if_id_valid <= 1'b0;
    end else if (redirect) begin
      // Flush wins over a simultaneous stall: one-bubble penalty.
      r_pc          <= redirect_pc;
      r_if_id_instr <= NOP;
      r_if_id_pc    <= '0;
      r_if_id_valid <= 1'b0;
    end else if (!stall) begin
      r_pc          <= w_pc_inc;
      r_if_id_instr <= w_fetch_instr;
      r_if_id_pc    <= r_pc;
      r_if_id_valid <= 1'b1;
    end
  end

  assign pc          = r_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_imm6  = r_if_id_instr[5:0];
  assign if_id_pc    = r_if_id_pc;
  assign if_id_valid = r_if_id_valid;

endmodule

// File: tb/tb_a2_fetch_stage.sv
module tb_a2_fetch_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_en;
  logic [5:0] load_addr;
  logic [7:0] load_data;
  logic       stall;
  logic       redirect;
  logic [5:0] redirect_pc;
  logic [5:0] pc;
  logic [7:0] if_id_instr;
  logic [5:0] if_id_imm6;
  logic [5:0] if_id_pc;
  logic       if_id_valid;

  int n_vec = 0;
  int n_err = 0;

  a2_fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc         (pc),
    .if_id_instr(if_id_instr),
    .if_id_imm6 (if_id_imm6),
    .if_id_pc   (if_id_pc),
    .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [7:0] instr, input logic [5:0] ipc,
                        input logic valid, input logic [5:0] npc);
    chk({tag, ".instr"}, 32'(if_id_instr), 32'(instr));
    chk({tag, ".imm6"},  32'(if_id_imm6),  32'(instr[5:0]));
    chk({tag, ".if_pc"}, 32'(if_id_pc),    32'(ipc));
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
    chk({tag, ".pc"},    32'(pc),          32'(npc));
  endtask

  task automatic load(input logic [5:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset for two cycles
    step();
    step();
    chk_if("reset", 8'h00, 6'd0, 1'b0, 6'd0);
    chk("reset.imm6_zero", 32'(if_id_imm6), 32'h00);

    // Load program
    reset = 1'b0;
    load(6'd0, 8'hF2);
    load(6'd1, 8'h1B);
    load(6'd2, 8'h32);
    load(6'd3, 8'h07);
    load(6'd62, 8'h2A);
    load(6'd63, 8'hC5);
    chk_if("loading", 8'h00, 6'd0, 1'b0, 6'd0);
    load_en = 1'b0;

    // Fetch sequence
    step();
    chk_if("fetch1", 8'hF2, 6'd0, 1'b1, 6'd1);
    chk("fetch1.imm6_lit", 32'(if_id_imm6), 32'h32);
    step();
    chk_if("fetch2", 8'h1B, 6'd1, 1'b1, 6'd2);

    // Stall three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_if("stall", 8'h1B, 6'd1, 1'b1, 6'd2);
    end
    stall = 1'b0;
    step();
    chk_if("resume", 8'h32, 6'd2, 1'b1, 6'd3);

    // Redirect with simultaneous stall
    redirect = 1'b1; redirect_pc = 6'd62; stall = 1'b1;
    step();
    chk_if("redir_flush", 8'h00, 6'd0, 1'b0, 6'd62);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk_if("redir_tgt", 8'h2A, 6'd62, 1'b1, 6'd63);

    // Wrap-around
    step();
    chk_if("wrap63", 8'hC5, 6'd63, 1'b1, 6'd0);
    step();
    chk_if("wrap0", 8'hF2, 6'd0, 1'b1, 6'd1);

    // Run up to pc=5 (mem[4] never loaded, so only pc/valid checked)
    for (int i = 0; i < 4; i++) step();
    chk("run.pc", 32'(pc), 32'd5);
    chk("run.valid", 32'(if_id_valid), 32'd1);
    chk("run.if_pc", 32'(if_id_pc), 32'd4);

    // Reset mid-run
    reset = 1'b1;
    step();
    chk_if("midreset", 8'h00, 6'd0, 1'b0, 6'd0);
    reset = 1'b0;
    step();
    chk_if("post_reset", 8'hF2, 6'd0, 1'b1, 6'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
